// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
// Holds the frame FSM encoding and the default line timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// The clear input restarts the period so a new bit always starts at count 0.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as start, data (LSB first), stop.
// All outputs are registered and loaded from the next-state values, so they change on the FSM edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_tx_d,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic                 stop_reg, stop_next;
  logic                 tx_reg, tx_next;
  logic                 ready_reg, busy_reg, done_reg, done_next;
  logic                 baud_clear, baud_tick;

  // Held clear while idle so the first start-bit cycle is always count 0
  assign baud_clear = (state_reg == IDLE) || (state_next != state_reg);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    stop_next  = stop_reg;
    case (state_reg)
      IDLE: begin
        if (i_tx_valid) begin
          state_next = START;
          shift_next = i_tx_d;
          bit_next   = '0;
          stop_next  = 1'b0;
        end
      end
      START: begin
        if (baud_tick) state_next = DATA;
      end
      DATA: begin
        if (baud_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == BIT_LAST) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_reg == STOP_LAST) begin
            stop_next  = 1'b0;
            state_next = IDLE;
          end else begin
            stop_next = stop_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level follows the state being entered, giving a registered o_tx with no extra latency
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign done_next = (state_reg == STOP) && (state_next == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      stop_reg  <= 1'b0;
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      stop_reg  <= stop_next;
      tx_reg    <= tx_next;
      ready_reg <= (state_next == IDLE);
      busy_reg  <= (state_next != IDLE);
      done_reg  <= done_next;
    end
  end

  assign o_tx       = tx_reg;
  assign o_tx_ready = ready_reg;
  assign o_tx_busy  = busy_reg;
  assign o_tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit, 8 data bits, 1 stop bit.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_tx_d = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready, o_tx, o_tx_busy, o_tx_done;

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit rx_en = 1'b0;
  logic [7:0] rx_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_tx_d    (i_tx_d),
    .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready),
    .o_tx      (o_tx),
    .o_tx_busy (o_tx_busy),
    .o_tx_done (o_tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_tx_done === 1'b1) done_cnt++;

  // Reference receiver: detects the start edge, samples each bit at its midpoint
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rx_en && o_tx === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (CPB) @(negedge clk);
        if (o_tx === 1'b1) rx_q.push_back(b);
        else rx_q.push_back(8'hxx);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (o_tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, o_tx_ready, 1);
  endtask

  // Called right after the accepting edge. mode 0: drop valid; 1: keep valid;
  // 2: drop valid, poke a new byte mid-DATA and toggle data throughout.
  task automatic frame_check(input logic [7:0] b, input int mode, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0 && mode != 1) i_tx_valid = 1'b0;
      if (mode == 2) begin
        i_tx_d = ~i_tx_d;
        if (k == 14) begin i_tx_valid = 1'b1; i_tx_d = 8'h3C; end
        if (k == 15) i_tx_valid = 1'b0;
      end
      chk($sformatf("%s tx k=%0d", tag, k), o_tx, fr[k / CPB]);
      if (k == 0 || k == FRAME - 1) begin
        chk($sformatf("%s busy k=%0d", tag, k), o_tx_busy, 1);
        chk($sformatf("%s ready k=%0d", tag, k), o_tx_ready, 0);
      end
      if (o_tx_done !== 1'b0) chk($sformatf("%s early done k=%0d", tag, k), o_tx_done, 0);
    end
    @(negedge clk);
    chk({tag, " done"}, o_tx_done, 1);
    chk({tag, " ready end"}, o_tx_ready, 1);
    chk({tag, " busy end"}, o_tx_busy, 0);
    chk({tag, " idle tx"}, o_tx, 1);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_tx_valid = 1'b1;
    i_tx_d = b;
    @(posedge clk);
  endtask

  initial begin
    int d0;
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst tx", o_tx, 1);
      chk("rst ready", o_tx_ready, 1);
      chk("rst busy", o_tx_busy, 0);
      chk("rst done", o_tx_done, 0);
    end

    // Single byte A5: line reads 0,1,0,1,0,0,1,0,1,1
    d0 = done_cnt;
    send(8'hA5);
    frame_check(8'hA5, 0, "A5");
    @(negedge clk);
    chk("A5 done width", o_tx_done, 0);
    chk("A5 done count", done_cnt - d0, 1);

    // Back-to-back 00 then FF with valid held high
    d0 = done_cnt;
    send(8'h00);
    frame_check(8'h00, 1, "b2b 00");
    i_tx_d = 8'hFF;
    @(posedge clk);
    frame_check(8'hFF, 1, "b2b FF");
    i_tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b done count", done_cnt - d0, 2);
    chk("b2b idle", o_tx, 1);

    // Busy ignore
    d0 = done_cnt;
    send(8'h96);
    frame_check(8'h96, 2, "busy");
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("no 2nd frame tx", o_tx, 1);
    end
    chk("busy done count", done_cnt - d0, 1);

    // Mid-frame reset during data bit 3 of 55
    d0 = done_cnt;
    send(8'h55);
    @(negedge clk);
    i_tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-rst busy", o_tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst tx", o_tx, 1);
    chk("mrst ready", o_tx_ready, 1);
    chk("mrst busy", o_tx_busy, 0);
    chk("mrst done", o_tx_done, 0);
    repeat (8) @(negedge clk);
    chk("mrst no done", done_cnt - d0, 0);
    send(8'h81);
    frame_check(8'h81, 0, "81");

    // Loopback through the reference receiver
    @(negedge clk);
    rx_q.delete();
    rx_en = 1'b1;
    begin
      logic [7:0] lb[4];
      lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hC3;
      for (int i = 0; i < 4; i++) begin
        wait_ready($sformatf("lb ready %0d", i));
        send(lb[i]);
        @(negedge clk);
        i_tx_valid = 1'b0;
      end
      wait_ready("lb final");
      repeat (4) @(negedge clk);
      chk("lb count", rx_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
        if (i < rx_q.size()) chk($sformatf("lb byte %0d", i), rx_q[i], lb[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
